// File: rtl/turbo_pkt_dispatch_if.sv
// rtl/turbo_pkt_dispatch_if.sv - FIFO read-port and per-channel signal bundle for turbo_pkt_dispatch
interface turbo_pkt_dispatch_if #(
    parameter int BUS    = 534,
    parameter int NUM_CH = 2,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [BUS-1:0]    fifo_q;
    logic              fifo_empty;
    logic              fifo_rdreq;
    logic [NUM_CH-1:0] ch_ready_in;
    logic [NUM_CH-1:0] ch_en;
    logic [BUS-1:0]    ch_data;
    logic [CH_W-1:0]   cur_ch;
    logic              busy;
    logic              pkt_done;

    // dispatcher side
    modport master (
        input  fifo_q, fifo_empty, ch_ready_in,
        output fifo_rdreq, ch_en, ch_data, cur_ch, busy, pkt_done
    );

    // FIFO / decoder side
    modport slave (
        output fifo_q, fifo_empty, ch_ready_in,
        input  fifo_rdreq, ch_en, ch_data, cur_ch, busy, pkt_done
    );
endinterface

// File: rtl/turbo_pkt_dispatch.sv
// rtl/turbo_pkt_dispatch.sv - packet dispatcher from FIFO to NUM_CH decoders; optional stats via DISPATCH_STATS_EN
module turbo_pkt_dispatch #(
    parameter int BUS           = 534,
    parameter int NUM_CH        = 2,
    parameter int BEATS_PER_PKT = 25,
    parameter int RD_SPACING    = 4,
    parameter int SEL_MODE      = 0
) (
    input  logic                 clk_st,
    input  logic                 rst,
    turbo_pkt_dispatch_if.master bus
`ifdef DISPATCH_STATS_EN
    ,
    output logic [NUM_CH*16-1:0] pkt_cnt,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BC_W  = (BEATS_PER_PKT > 1) ? $clog2(BEATS_PER_PKT) : 1;
    localparam int SP_W  = (RD_SPACING > 1) ? $clog2(RD_SPACING) : 1;
    localparam int PAD_N = 1 << CH_W;

    localparam logic [0:0] ST_SEL  = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]        state;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   cur_ch;
    logic [CH_W-1:0]   en_ch;
    logic [CH_W-1:0]   cand;
    logic [CH_W-1:0]   sel_ch;
    logic              sel_found;
    logic [BC_W-1:0]   beat_cnt;
    logic [SP_W-1:0]   spc_cnt;
    logic              rdreq;
    logic              rd_last;
    logic              rd_go;
    logic              beat_last;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] en_oh;
    logic              pkt_done;
    logic [PAD_N-1:0]  rdy_pad;
    int                scan_idx;

    // widen the ready vector so every CH_W-bit channel index lands in range
    always_comb begin
        rdy_pad = '0;
        rdy_pad[NUM_CH-1:0] = bus.ch_ready_in;
    end

    assign cand = (ptr == CH_W'(NUM_CH - 1)) ? '0 : ptr + CH_W'(1);

    // pick the channel to lock: strict candidate, or first ready one scanning upward with wrap
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = cand;
        scan_idx  = 0;
        if (SEL_MODE == 0) begin
            sel_found = rdy_pad[cand];
        end else begin
            // walk offsets high to low so the nearest ready channel wins
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                scan_idx = int'(cand) + i;
                if (scan_idx >= NUM_CH) begin
                    scan_idx = scan_idx - NUM_CH;
                end
                if (rdy_pad[CH_W'(scan_idx)]) begin
                    sel_found = 1'b1;
                    sel_ch    = CH_W'(scan_idx);
                end
            end
        end
    end

    assign rd_go     = (state == ST_XFER) && !bus.fifo_empty && rdy_pad[cur_ch] && (spc_cnt == '0);
    assign beat_last = (beat_cnt == BC_W'(BEATS_PER_PKT - 1));

    // channel lock / release and beat counting within the locked packet
    always_ff @(posedge clk_st or posedge rst) begin
        if (rst) begin
            state    <= ST_SEL;
            ptr      <= CH_W'(NUM_CH - 1);
            cur_ch   <= '0;
            beat_cnt <= '0;
        end else if (state == ST_SEL) begin
            if (sel_found) begin
                cur_ch <= sel_ch;
                ptr    <= sel_ch;
                state  <= ST_XFER;
            end
        end else begin
            if (rd_go) begin
                if (beat_last) begin
                    beat_cnt <= '0;
                    state    <= ST_SEL;
                end else begin
                    beat_cnt <= beat_cnt + BC_W'(1);
                end
            end
        end
    end

    // pop strobe, pop spacing, and capture of the beat's destination for the next cycle
    always_ff @(posedge clk_st or posedge rst) begin
        if (rst) begin
            rdreq   <= 1'b0;
            spc_cnt <= '0;
            en_ch   <= '0;
            rd_last <= 1'b0;
        end else begin
            rdreq <= rd_go;
            if (rd_go) begin
                spc_cnt <= SP_W'(RD_SPACING - 1);
                en_ch   <= cur_ch;
                rd_last <= beat_last;
            end else if (spc_cnt != '0) begin
                spc_cnt <= spc_cnt - SP_W'(1);
            end
        end
    end

    // one-hot decode of the captured destination; the last beat still targets the old channel
    always_comb begin
        en_oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            en_oh[i] = (en_ch == CH_W'(i));
        end
    end

    // beat strobe follows the pop by one cycle, when FIFO data is valid
    always_ff @(posedge clk_st or posedge rst) begin
        if (rst) begin
            ch_en    <= '0;
            pkt_done <= 1'b0;
        end else begin
            ch_en    <= rdreq ? en_oh : '0;
            pkt_done <= rdreq & rd_last;
        end
    end

    assign bus.fifo_rdreq = rdreq;
    assign bus.ch_en      = ch_en;
    assign bus.ch_data    = bus.fifo_q;
    assign bus.cur_ch     = cur_ch;
    assign bus.busy       = (state == ST_XFER);
    assign bus.pkt_done   = pkt_done;

`ifdef DISPATCH_STATS_EN
    logic stall_now;

    assign stall_now = (state == ST_XFER) && !bus.fifo_empty && (spc_cnt == '0) && !rdy_pad[cur_ch];

    // per-channel wrapping packet counters
    always_ff @(posedge clk_st or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (pkt_done && ch_en[i]) begin
                    pkt_cnt[i*16 +: 16] <= pkt_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end

    // saturating count of cycles lost to the locked channel not being ready
    always_ff @(posedge clk_st or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_now && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_turbo_pkt_dispatch.sv
// tb/tb_turbo_pkt_dispatch.sv - self-checking bench for turbo_pkt_dispatch
module tb_turbo_pkt_dispatch;

    localparam int A_SP  = 4;
    localparam int A_BPP = 25;

    logic clk_st = 1'b0;
    logic rst;

    always #5 clk_st = ~clk_st;

    turbo_pkt_dispatch_if #(.BUS(16), .NUM_CH(2)) ifa ();
    turbo_pkt_dispatch_if #(.BUS(16), .NUM_CH(4)) ifb ();
    turbo_pkt_dispatch_if #(.BUS(16), .NUM_CH(4)) ifc ();
    turbo_pkt_dispatch_if #(.BUS(16), .NUM_CH(3)) ifd ();

`ifdef DISPATCH_STATS_EN
    logic [31:0] pkt_cnt_a;
    logic [15:0] stall_cnt_a;
    logic [63:0] pkt_cnt_b;
    logic [15:0] stall_cnt_b;
    logic [63:0] pkt_cnt_c;
    logic [15:0] stall_cnt_c;
    logic [47:0] pkt_cnt_d;
    logic [15:0] stall_cnt_d;
`endif

    turbo_pkt_dispatch #(.BUS(16), .NUM_CH(2), .BEATS_PER_PKT(A_BPP), .RD_SPACING(A_SP), .SEL_MODE(0)) dut_a (
        .clk_st(clk_st), .rst(rst), .bus(ifa)
`ifdef DISPATCH_STATS_EN
        , .pkt_cnt(pkt_cnt_a), .stall_cnt(stall_cnt_a)
`endif
    );

    turbo_pkt_dispatch #(.BUS(16), .NUM_CH(4), .BEATS_PER_PKT(2), .RD_SPACING(1), .SEL_MODE(1)) dut_b (
        .clk_st(clk_st), .rst(rst), .bus(ifb)
`ifdef DISPATCH_STATS_EN
        , .pkt_cnt(pkt_cnt_b), .stall_cnt(stall_cnt_b)
`endif
    );

    turbo_pkt_dispatch #(.BUS(16), .NUM_CH(4), .BEATS_PER_PKT(2), .RD_SPACING(1), .SEL_MODE(0)) dut_c (
        .clk_st(clk_st), .rst(rst), .bus(ifc)
`ifdef DISPATCH_STATS_EN
        , .pkt_cnt(pkt_cnt_c), .stall_cnt(stall_cnt_c)
`endif
    );

    turbo_pkt_dispatch #(.BUS(16), .NUM_CH(3), .BEATS_PER_PKT(1), .RD_SPACING(1), .SEL_MODE(0)) dut_d (
        .clk_st(clk_st), .rst(rst), .bus(ifd)
`ifdef DISPATCH_STATS_EN
        , .pkt_cnt(pkt_cnt_d), .stall_cnt(stall_cnt_d)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        oh_idx = -1;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) oh_idx = i;
        end
    endfunction

    // ---------------- behavioural model of dut_a ----------------
    // packet-level view: locked or choosing, beats taken, edges since the last pop
    bit          m_lock;
    int          m_ch, m_ptr, m_beats, m_since, m_rd_ch, m_stall, m_c;
    bit          m_rd, m_rd_last, m_done, m_allowed;
    logic [1:0]  m_en;

    always @(posedge clk_st or posedge rst) begin
        if (rst) begin
            m_lock = 0; m_ch = 0; m_ptr = 1; m_beats = 0; m_since = A_SP;
            m_rd = 0; m_rd_ch = 0; m_rd_last = 0; m_en = 2'b00; m_done = 0; m_stall = 0;
        end else begin
            m_en      = m_rd ? (2'b01 << m_rd_ch) : 2'b00;
            m_done    = m_rd && m_rd_last;
            m_rd      = 0;
            m_allowed = (m_since >= A_SP);
            if (!m_lock) begin
                m_c = (m_ptr + 1) % 2;
                if (ifa.ch_ready_in[m_c]) begin
                    m_lock = 1; m_ch = m_c; m_ptr = m_c;
                end
            end else if (!ifa.fifo_empty && m_allowed) begin
                if (ifa.ch_ready_in[m_ch]) begin
                    m_rd = 1; m_rd_ch = m_ch; m_beats++;
                    m_rd_last = (m_beats == A_BPP);
                    if (m_rd_last) begin
                        m_beats = 0; m_lock = 0;
                    end
                end else if (m_stall < 65535) begin
                    m_stall++;
                end
            end
            if (m_rd) m_since = 1;
            else if (m_since < 1000) m_since++;
        end
    end

    // ---------------- per-cycle compare for dut_a ----------------
    int cyc = 0, a_ch0 = 0, a_ch1 = 0, a_total = 0, a_done_n = 0;
    int last_en = -1, gap_min = 1000, gap_max = 0;
    int done_at[3];

    always @(negedge clk_st) begin
        if (!rst) begin
            cyc++;
            check("a_rdreq",    ifa.fifo_rdreq, m_rd);
            check("a_ch_en",    ifa.ch_en,      m_en);
            check("a_pkt_done", ifa.pkt_done,   m_done);
            check("a_busy",     ifa.busy,       m_lock);
            check("a_cur_ch",   ifa.cur_ch,     m_ch);
            check("a_ch_data",  ifa.ch_data,    ifa.fifo_q);
`ifdef DISPATCH_STATS_EN
            check("a_stall_cnt", stall_cnt_a, m_stall);
`endif
            if (ifa.ch_en != 2'b00) begin
                a_total++;
                if (ifa.ch_en[0]) a_ch0++;
                if (ifa.ch_en[1]) a_ch1++;
                if (last_en >= 0) begin
                    if (cyc - last_en < gap_min) gap_min = cyc - last_en;
                    if (cyc - last_en > gap_max) gap_max = cyc - last_en;
                end
                last_en = cyc;
                if (ifa.pkt_done && a_done_n < 3) begin
                    done_at[a_done_n] = a_total;
                    a_done_n++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    int steps = 0;

    task automatic step();
        @(posedge clk_st);
        #1;
        steps++;
        ifa.fifo_q = ifa.fifo_q + 16'd1;
    endtask

    int k, k1, c0, c1, dn, rq, hb, n, dd;
    int bseq[3];
    int cseq[3];
    int dch[4];
    int dcy[4];

    initial begin
        rst = 1'b1;
        ifa.fifo_q = 16'h0; ifa.fifo_empty = 1'b1; ifa.ch_ready_in = '0;
        ifb.fifo_q = 16'h0b; ifb.fifo_empty = 1'b1; ifb.ch_ready_in = '0;
        ifc.fifo_q = 16'h0c; ifc.fifo_empty = 1'b1; ifc.ch_ready_in = '0;
        ifd.fifo_q = 16'h0d; ifd.fifo_empty = 1'b1; ifd.ch_ready_in = '0;
        for (int i = 0; i < 3; i++) begin
            bseq[i] = -1; cseq[i] = -1;
        end
        repeat (3) step();

        check("rst_rdreq",    ifa.fifo_rdreq, 0);
        check("rst_ch_en",    ifa.ch_en,      0);
        check("rst_busy",     ifa.busy,       0);
        check("rst_pkt_done", ifa.pkt_done,   0);
        check("rst_cur_ch",   ifa.cur_ch,     0);

        // three packets, all ready, FIFO never empty
        rst = 1'b0;
        ifa.ch_ready_in = 2'b11;
        ifa.fifo_empty  = 1'b0;
        for (int i = 0; i < 1000 && a_done_n < 3; i++) step();
        check("t1_pkts",      a_done_n, 3);
        check("t1_ch0_beats", a_ch0, 50);
        check("t1_ch1_beats", a_ch1, 25);
        check("t1_done_at0",  done_at[0], 25);
        check("t1_done_at1",  done_at[1], 50);
        check("t1_done_at2",  done_at[2], 75);
        check("t1_gap_min",   gap_min, 4);
        check("t1_gap_max",   gap_max, 4);

        // async reset on beat 7 of the following packet on ch1
        k = 0;
        for (int i = 0; i < 300 && k < 7; i++) begin
            step();
            if (ifa.ch_en[1]) k++;
        end
        check("t6_beats_seen", k, 7);
        check("t6_busy_pre",   ifa.busy, 1);
        check("t6_cur_pre",    ifa.cur_ch, 1);
        rst = 1'b1;
        #1;
        check("t6_async_ch_en", ifa.ch_en, 0);
        check("t6_async_busy",  ifa.busy, 0);
        check("t6_async_cur",   ifa.cur_ch, 0);
        check("t6_async_rdreq", ifa.fifo_rdreq, 0);
        check("t6_async_done",  ifa.pkt_done, 0);
        repeat (2) step();
        rst = 1'b0;

        // mid-packet stalls on ch0: ready low 20 cycles, then empty 8 cycles
        k = 0; k1 = 0;
        for (int i = 0; i < 300 && k < 10; i++) begin
            step();
            if (ifa.ch_en[0]) k++;
            if (ifa.ch_en[1]) k1++;
        end
        check("t4_first_beats", k, 10);
        check("t4_no_ch1_first", k1, 0);
        rq = 0;
        ifa.ch_ready_in = 2'b10;
        repeat (20) begin step(); rq += int'(ifa.fifo_rdreq); end
        ifa.ch_ready_in = 2'b11;
        ifa.fifo_empty  = 1'b1;
        repeat (8) begin step(); rq += int'(ifa.fifo_rdreq); end
        ifa.fifo_empty = 1'b0;
        check("t4_no_rdreq_in_stall", rq, 0);
        c0 = 0; c1 = 0; dn = 0;
        for (int i = 0; i < 400 && dn == 0; i++) begin
            step();
            if (ifa.ch_en[0]) c0++;
            if (ifa.ch_en[1]) c1++;
            if (ifa.pkt_done && ifa.ch_en[0]) dn = 1;
        end
        check("t4_rest_beats_ch0", c0, 15);
        check("t4_rest_beats_ch1", c1, 0);
        check("t4_pkt_done",       dn, 1);
`ifdef DISPATCH_STATS_EN
        check("t4_stall_cnt", stall_cnt_a, 18);
        step();
        check("t4_pkt_cnt0", pkt_cnt_a[15:0], 1);
        check("t4_pkt_cnt1", pkt_cnt_a[31:16], 0);
`endif
        ifa.fifo_empty  = 1'b1;
        ifa.ch_ready_in = 2'b00;

        // next-ready rotation skips ch2
        ifb.ch_ready_in = 4'b1010;
        ifb.fifo_empty  = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && n < 3; i++) begin
            step();
            if (ifb.pkt_done) begin bseq[n] = oh_idx(ifb.ch_en); n++; end
        end
        check("b_pkts", n, 3);
        check("b_seq0", bseq[0], 1);
        check("b_seq1", bseq[1], 3);
        check("b_seq2", bseq[2], 1);
        ifb.fifo_empty  = 1'b1;
        ifb.ch_ready_in = '0;

        // strict rotation waits on candidate ch2
        ifc.ch_ready_in = 4'b0011;
        ifc.fifo_empty  = 1'b0;
        n = 0;
        for (int i = 0; i < 200 && n < 2; i++) begin
            step();
            if (ifc.pkt_done) begin cseq[n] = oh_idx(ifc.ch_en); n++; end
        end
        check("c_pkts", n, 2);
        check("c_seq0", cseq[0], 0);
        check("c_seq1", cseq[1], 1);
        ifc.ch_ready_in = 4'b1010;
        hb = 0;
        repeat (10) begin
            step();
            if (ifc.busy) hb++;
            if (ifc.cur_ch != 2'd1) hb++;
        end
        check("c_wait_idle", hb, 0);
        ifc.ch_ready_in = 4'b1110;
        step();
        check("c_lock_busy", ifc.busy, 1);
        check("c_lock_ch",   ifc.cur_ch, 2);
        n = 0;
        for (int i = 0; i < 50 && n < 1; i++) begin
            step();
            if (ifc.pkt_done) begin cseq[2] = oh_idx(ifc.ch_en); n++; end
        end
        check("c_seq2", cseq[2], 2);
        ifc.fifo_empty  = 1'b1;
        ifc.ch_ready_in = '0;

        // single-beat packets, back-to-back spacing, three channels
        ifd.ch_ready_in = 3'b111;
        ifd.fifo_empty  = 1'b0;
        n = 0; dd = 0;
        for (int i = 0; i < 100 && n < 4; i++) begin
            step();
            if (ifd.ch_en != 3'b000) begin
                dch[n] = oh_idx({1'b0, ifd.ch_en});
                dcy[n] = steps;
                if (ifd.pkt_done) dd++;
                n++;
            end
        end
        check("d_beats", n, 4);
        check("d_ch0", dch[0], 0);
        check("d_ch1", dch[1], 1);
        check("d_ch2", dch[2], 2);
        check("d_ch3", dch[3], 0);
        check("d_gap1", dcy[1] - dcy[0], 2);
        check("d_gap2", dcy[2] - dcy[1], 2);
        check("d_gap3", dcy[3] - dcy[2], 2);
        check("d_done_each", dd, 4);
        ifd.fifo_empty  = 1'b1;
        ifd.ch_ready_in = '0;

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
